apb_sccb_master: RTL
====================

# apb_sccb_master

APB-programmable SCCB master that loads the OV5640 camera's configuration registers before video capture starts. It sits on the APB bus next to the camera-to-HDMI peripheral and drives the camera's SCCB clock and data lines. Firmware issues single 3-phase write or 2-phase-write/2-phase-read transactions with a 16-bit register address and 8-bit data, then polls or takes an interrupt on completion.

## Interface
Parameters:
- CLK_DIV, 125, PCLK cycles per SCL quarter-period. SCL period is 4·CLK_DIV cycles (100 kHz at 50 MHz). Legal range is 2..65535.
- DEV_ADDR, 7'h3C, 7-bit SCCB device ID. The write ID byte is {DEV_ADDR,0} = 0x78; the read ID byte is {DEV_ADDR,1} = 0x79.

Ports:
- PCLK  in  1  clock. This is the only clock.
- PRESETN  in  1  reset, synchronous, active-low.
- PSEL  in  1  APB select.
- PADDR  in  [11:2]  APB word address.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB direction (1 = write).
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied to 1.
- PSLVERR  out  1  tied to 0.
- sccb_scl  out  1  SCL. Idles at 1.
- sccb_sda_o  out  1  tied to 0 (open-drain).
- sccb_sda_oe  out  1  1 pulls SDA low; 0 releases SDA.
- sccb_sda_i  in  1  SDA pad input.
- irq  out  1  level interrupt.

## Operation
Registers, addressed by byte offset ({PADDR,2'b00}):
- 0x00 CTRL:
  - bit0 START: write-1 only, reads 0.
  - bit1 RD: 1 = read transaction.
  - bit2 IRQ_EN.
- 0x04 REGADDR[15:0].
- 0x08 WDATA[7:0].
- 0x0C STATUS:
  - bit0 BUSY: read-only.
  - bit1 DONE: sticky, write-1-to-clear.
  - bit2 NACK: sticky, write-1-to-clear.
- 0x10 RDATA[7:0]: read-only.

APB rules:
- A write takes effect on a cycle with PSEL & PENABLE & PWRITE.
- PRDATA is combinational: the addressed register when PSEL & ~PWRITE, otherwise 0. Unmapped offsets read 0.
- While BUSY, writes to CTRL, REGADDR and WDATA are ignored. STATUS W1C is always accepted.
- A START write with BUSY=0 clears DONE and NACK, latches RD, and launches the transaction.

Transaction sequences:
- Write: S, 0x78, X, REGADDR[15:8], X, REGADDR[7:0], X, WDATA, X, P.
- Read: S, 0x78, X, ADDR_H, X, ADDR_L, X, P, then S, 0x79, X, 8 bits sampled into RDATA, NA (SDA released), P.
- All bytes are sent MSB first. X is the 9th bit: the master releases SDA and samples it.

FSM states and transitions:
- IDLE → START → TX_BIT → TX_ACK.
- TX_ACK → TX_BIT for the next byte, or → STOP.
- STOP → START for the read phase, or → IDLE.
- A read phase runs START → TX_BIT / TX_ACK (0x79) → RX_BIT → RX_NA → STOP → IDLE.

Irq: irq = IRQ_EN & (DONE | NACK).

## Timing
Bit timing:
- A 16-bit divider produces a tick every CLK_DIV cycles. A 2-bit quarter counter advances on each tick.
- Data bit: SCL is 0 in q0–q1 and 1 in q2–q3. SDA changes at entry to q0. SDA is sampled on the tick that ends q2.
- START: SDA released in q0–q1, pulled low in q2–q3, with SCL=1 throughout.
- STOP: SCL=0 in q0, 1 in q1–q3. SDA is low in q0–q1 and released in q2–q3.

Latency (BUSY goes 1 the cycle after the START write):
- Write: 152 quarters = 152·CLK_DIV cycles.
- Read: 196 quarters.
- DONE=1 and BUSY=0 are set in the same cycle, the cycle after the final STOP tick.

Reset values:
- sccb_scl=1, sccb_sda_oe=0, irq=0.
- All registers 0. The FSM is in IDLE with divider and counters at 0.
- A reset asserted mid-transaction releases the bus on the next PCLK edge. The partial transfer is abandoned with no STOP.

## Configuration
- SCCB_ACK_CHECK_EN defined:
  - A 1 sampled in any TX_ACK sets NACK.
  - The FSM then jumps to STOP → IDLE, with BUSY cleared and DONE left 0.
- SCCB_ACK_CHECK_EN undefined: the X bit is don't-care per SCCB. NACK never sets, and every transaction ends with DONE=1.

## Test plan
All scenarios use CLK_DIV=4 and a slave model on SDA.
1. Reset: hold PRESETN=0 for 3 cycles → sccb_scl=1, sccb_sda_oe=0, irq=0, STATUS=0, RDATA=0.
2. Write transaction: REGADDR=0x3008, WDATA=0x82, CTRL=0x5 → bytes 0x78, 0x30, 0x08, 0x82 captured at SCL rises. BUSY lasts 608 cycles, then STATUS=0x2 and irq=1. W1C of STATUS=0x2 → irq=0.
3. Read transaction: REGADDR=0x300A, CTRL=0x3, slave returns 0x56 → bytes 0x78, 0x30, 0x0A, P, S, 0x79. SDA is released on NA. RDATA=0x56 and DONE=1 after 784 cycles.
4. Busy lockout: CTRL=0x1 issued, then mid-transfer REGADDR=0x1234 and CTRL=0x1 written → REGADDR unchanged and no second transaction. Exactly one DONE.
5. NACK: slave NACKs the 2nd byte. With SCCB_ACK_CHECK_EN → STATUS=0x4 and a STOP follows immediately. Without it → STATUS=0x2 and all 4 bytes are sent.
6. Reset mid-transfer: PRESETN=0 during the 3rd byte → next edge sccb_scl=1, sccb_sda_oe=0, STATUS=0. After release, a new write completes normally.

Source files
------------

// File: rtl/apb_sccb_master_if.sv
// APB slave-side bus bundle for apb_sccb_master.
// The master modport is the bus initiator (CPU side); the slave modport is the peripheral.
interface apb_sccb_master_if;
    logic        PSEL;
    logic [11:2] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PADDR, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_sccb_master.sv
// APB-programmable SCCB master for OV5640 register loading.
// Issues 3-phase writes or 2-phase-write + 2-phase-read transactions with a
// 16-bit register address. Optional macro SCCB_ACK_CHECK_EN: when defined, a
// high ACK bit aborts the transfer (STOP, NACK set, DONE left 0).
module apb_sccb_master #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h3C
) (
    input  logic                      PCLK,
    input  logic                      PRESETN,
    apb_sccb_master_if.slave          apb,
    output logic                      sccb_scl,
    output logic                      sccb_sda_o,
    output logic                      sccb_sda_oe,
    input  logic                      sccb_sda_i,
    output logic                      irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TX_BIT, S_TX_ACK, S_RX_BIT, S_RX_NA, S_STOP
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [7:0]  sh_q, sh_d;
    logic        phase2_q, phase2_d;
    logic        abort_q, abort_d;
    logic        rd_q, rd_d;
    logic        irq_en_q, irq_en_d;
    logic [15:0] regaddr_q, regaddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        busy, tick, qend, qsamp, wr_en, mapped;
    logic [2:0]  off;
    logic        unused_pwdata;

    assign busy   = (state_q != S_IDLE);
    assign tick   = (div_q == DIV_LAST);
    assign qend   = tick && (qtr_q == 2'd3);
    assign qsamp  = tick && (qtr_q == 2'd2);
    assign wr_en  = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign mapped = (apb.PADDR[11:5] == 7'd0);
    assign off    = apb.PADDR[4:2];
    assign unused_pwdata = ^apb.PWDATA[31:16];

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign sccb_sda_o  = 1'b0;
    assign irq         = irq_en_q & (done_q | nack_q);

    // Byte to shift out: phase 2 always sends the read ID, phase 1 walks ID/ADDR_H/ADDR_L/WDATA.
    function automatic logic [7:0] tx_byte(input logic p2, input logic [1:0] idx,
                                           input logic [15:0] ra, input logic [7:0] wd);
        if (p2) return {DEV_ADDR, 1'b1};
        case (idx)
            2'd0:    return {DEV_ADDR, 1'b0};
            2'd1:    return ra[15:8];
            2'd2:    return ra[7:0];
            default: return wd;
        endcase
    endfunction

    // APB register reads: combinational, zero when not a selected read.
    always_comb begin
        apb.PRDATA = 32'd0;
        if (apb.PSEL && !apb.PWRITE && mapped) begin
            case (off)
                3'd0:    apb.PRDATA = {29'd0, irq_en_q, rd_q, 1'b0};
                3'd1:    apb.PRDATA = {16'd0, regaddr_q};
                3'd2:    apb.PRDATA = {24'd0, wdata_q};
                3'd3:    apb.PRDATA = {29'd0, nack_q, done_q, busy};
                3'd4:    apb.PRDATA = {24'd0, rdata_q};
                default: apb.PRDATA = 32'd0;
            endcase
        end
    end

    // Next-state: APB register writes, bit-timing divider and transaction FSM.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sh_d      = sh_q;
        phase2_d  = phase2_q;
        abort_d   = abort_q;
        rd_d      = rd_q;
        irq_en_d  = irq_en_q;
        regaddr_d = regaddr_q;
        wdata_d   = wdata_q;
        done_d    = done_q;
        nack_d    = nack_q;
        rdata_d   = rdata_q;

        if (wr_en && mapped) begin
            case (off)
                3'd0: if (!busy) begin
                    rd_d     = apb.PWDATA[1];
                    irq_en_d = apb.PWDATA[2];
                    if (apb.PWDATA[0]) begin
                        state_d  = S_START;
                        div_d    = 16'd0;
                        qtr_d    = 2'd0;
                        phase2_d = 1'b0;
                        abort_d  = 1'b0;
                        done_d   = 1'b0;
                        nack_d   = 1'b0;
                    end
                end
                3'd1: if (!busy) regaddr_d = apb.PWDATA[15:0];
                3'd2: if (!busy) wdata_d = apb.PWDATA[7:0];
                3'd3: begin
                    if (apb.PWDATA[1]) done_d = 1'b0;
                    if (apb.PWDATA[2]) nack_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (busy) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        case (state_q)
            S_START: if (qend) begin
                state_d = S_TX_BIT;
                sh_d    = tx_byte(phase2_q, 2'd0, regaddr_q, wdata_q);
                bit_d   = 3'd0;
                byte_d  = 2'd0;
            end
            S_TX_BIT: if (qend) begin
                if (bit_q == 3'd7) begin
                    state_d = S_TX_ACK;
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = {sh_q[6:0], 1'b0};
                end
            end
            S_TX_ACK: begin
`ifdef SCCB_ACK_CHECK_EN
                if (qsamp && sccb_sda_i) begin
                    nack_d  = 1'b1;
                    abort_d = 1'b1;
                end
`endif
                if (qend) begin
                    bit_d = 3'd0;
                    if (abort_q) begin
                        state_d = S_STOP;
                    end else if (phase2_q) begin
                        state_d = S_RX_BIT;
                    end else if (byte_q == (rd_q ? 2'd2 : 2'd3)) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_TX_BIT;
                        byte_d  = byte_q + 2'd1;
                        sh_d    = tx_byte(1'b0, byte_q + 2'd1, regaddr_q, wdata_q);
                    end
                end
            end
            S_RX_BIT: begin
                if (qsamp) sh_d = {sh_q[6:0], sccb_sda_i};
                if (qend) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_RX_NA;
                        rdata_d = sh_q;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_RX_NA: if (qend) state_d = S_STOP;
            S_STOP: if (qend) begin
                if (rd_q && !phase2_q && !abort_q) begin
                    state_d  = S_START;
                    phase2_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    if (!abort_q) done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Bus pin levels derived from the current state and quarter.
    always_comb begin
        sccb_scl    = 1'b1;
        sccb_sda_oe = 1'b0;
        case (state_q)
            S_START:  sccb_sda_oe = qtr_q[1];
            S_TX_BIT: begin
                sccb_scl    = qtr_q[1];
                sccb_sda_oe = ~sh_q[7];
            end
            S_TX_ACK, S_RX_BIT, S_RX_NA: sccb_scl = qtr_q[1];
            S_STOP: begin
                sccb_scl    = (qtr_q != 2'd0);
                sccb_sda_oe = ~qtr_q[1];
            end
            default: ;
        endcase
    end

    // State and register update with synchronous active-low reset.
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q   <= S_IDLE;
            div_q     <= 16'd0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            sh_q      <= 8'd0;
            phase2_q  <= 1'b0;
            abort_q   <= 1'b0;
            rd_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            regaddr_q <= 16'd0;
            wdata_q   <= 8'd0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sh_q      <= sh_d;
            phase2_q  <= phase2_d;
            abort_q   <= abort_d;
            rd_q      <= rd_d;
            irq_en_q  <= irq_en_d;
            regaddr_q <= regaddr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule
